// File: rtl/shift_add_mult_pkg.sv
// shift_add_mult_pkg
// Shared definitions for the shift-and-add multiplier: the controller
// state encoding and the default operand width.
// Configuration macro: EARLY_TERM_EN (used by shift_add_mult_ctrl).
package shift_add_mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int DEFAULT_WIDTH = 16;

    // Controller states; ready/busy/done decode one state each.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_dp.sv
// shift_add_dp
// Datapath of the shift-and-add multiplier. Holds the multiplicand, the
// accumulator and the multiplier/low-product register. A load strobe
// clears the accumulator and captures both operands; a step strobe
// performs one add-and-shift.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   i_load       capture operands, clear accumulator
//   i_step       perform one add/shift step
//   i_mcand      multiplicand to capture on load
//   i_mplier     multiplier to capture on load
//   o_shifted    {sum, mreg} >> 1 for the current step (2*WIDTH bits)
module shift_add_dp
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_shifted
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mreg;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH:0]   w_sum;

    // The adder is one bit wider than the operands so the carry-out lands
    // in the top bit of the shifted result instead of being dropped.
    always_comb begin
        w_sum     = {1'b0, r_acc} + (r_mreg[0] ? {1'b0, r_mcand} : '0);
        o_shifted = {w_sum, r_mreg[WIDTH-1:1]};
    end

    // Operand capture and add/shift register; load has priority over step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mreg  <= '0;
            r_mcand <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_mreg  <= i_mplier;
            r_mcand <= i_mcand;
        end else if (i_step) begin
            r_acc  <= o_shifted[2*WIDTH-1:WIDTH];
            r_mreg <= o_shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
// Sequential unsigned multiplier controller. A request is accepted in
// IDLE when start is high; the operands are then multiplied one bit per
// cycle in RUN by the shift_add_dp datapath, and the product is latched
// into answer on the way to a single-cycle DONE.
// Configuration macro: EARLY_TERM_EN -- when defined, RUN ends as soon as
// the remaining multiplier bits are all zero, the result being shifted
// into its final position in the same edge.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             request, sampled only while ready is high
//   input1, input2    multiplicand / multiplier (unsigned, WIDTH bits)
//   ready, busy, done one-hot state decodes (IDLE, RUN, DONE)
//   answer            2*WIDTH-bit product, held until the next DONE
module shift_add_mult_ctrl
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] answer
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_answer;
    logic [2*WIDTH-1:0] w_shifted;
    logic [2*WIDTH-1:0] w_final;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_mcand   (input1),
        .i_mplier  (input2),
        .o_shifted (w_shifted)
    );

`ifdef EARLY_TERM_EN
    // Shadow of the multiplier bits not yet consumed; once everything above
    // the current bit is zero, the remaining steps would only add zero, so
    // they collapse into a single shift by the remaining step count.
    logic [WIDTH-1:0] r_mrem;
    logic [CNT_W-1:0] w_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mrem <= '0;
        end else if (w_load) begin
            r_mrem <= input2;
        end else if (w_step) begin
            r_mrem <= r_mrem >> 1;
        end
    end

    always_comb begin
        w_rem   = LAST_CNT - r_cnt;
        w_last  = (r_cnt == LAST_CNT) || (r_mrem[WIDTH-1:1] == '0);
        w_final = w_shifted >> w_rem;
    end
`else
    // Full-length run: the product is complete after the WIDTH-th step.
    always_comb begin
        w_last  = (r_cnt == LAST_CNT);
        w_final = w_shifted;
    end
`endif

    // Next-state and datapath strobes; start is only looked at in IDLE.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, step counter and result register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_answer <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_step && w_last) begin
                r_answer <= w_final;
            end
        end
    end

    always_comb begin
        ready  = (r_state == IDLE);
        busy   = (r_state == RUN);
        done   = (r_state == DONE);
        answer = r_answer;
    end

endmodule
